// File: rtl/tone_gen_if.sv
// Control and sample bundle between the tone generator and its user/serializer side.
// Samples carry no handshake: audio_l/audio_r/vol are always valid and may be sampled at any time.
interface tone_gen_if #(
  parameter int DIV_W = 22
);
  logic [DIV_W-1:0] div_l;
  logic [DIV_W-1:0] div_r;
  logic             vol_up;
  logic             vol_dn;
  logic             mute;
  logic [2:0]       vol;
  logic [15:0]      audio_l;
  logic [15:0]      audio_r;

  modport master (
    output div_l, div_r, vol_up, vol_dn, mute,
    input  vol, audio_l, audio_r
  );

  modport slave (
    input  div_l, div_r, vol_up, vol_dn, mute,
    output vol, audio_l, audio_r
  );
endinterface

// File: rtl/tone_gen.sv
// Stereo square-wave tone generator with per-channel half-period divisors and a
// saturating 3-bit volume driven by edge-detected up/down buttons.
module tone_gen #(
  parameter int DIV_W     = 22,
  parameter int AMP_SHIFT = 12,
  parameter int VOL_INIT  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  tone_gen_if.slave   bus
);

  logic [DIV_W-1:0] div_in [2];
  logic [DIV_W-1:0] cnt    [2];
  logic [DIV_W-1:0] div_q  [2];
  logic             phase  [2];
  logic [15:0]      sample_next [2];
  logic [15:0]      audio_q     [2];

  logic [2:0]  vol_q;
  logic [2:0]  vol_next;
  logic        up_q;
  logic        dn_q;
  logic        up_edge;
  logic        dn_edge;
  logic [15:0] amp;
  logic [15:0] amp_neg;

  assign div_in[0] = bus.div_l;
  assign div_in[1] = bus.div_r;

  assign up_edge = bus.vol_up & ~up_q;
  assign dn_edge = bus.vol_dn & ~dn_q;

  assign amp     = 16'(vol_q) << AMP_SHIFT;
  assign amp_neg = 16'd0 - amp;

  always_comb begin
    vol_next = vol_q;
    if (up_edge && !dn_edge && vol_q != 3'd7) begin
      vol_next = vol_q + 3'd1;
    end else if (dn_edge && !up_edge && vol_q != 3'd0) begin
      vol_next = vol_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vol_q <= 3'(VOL_INIT);
      up_q  <= 1'b0;
      dn_q  <= 1'b0;
    end else begin
      vol_q <= vol_next;
      up_q  <= bus.vol_up;
      dn_q  <= bus.vol_dn;
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    // The divisor is only re-latched at a half-period boundary (or while silent),
    // so cnt never exceeds div_q-1 and the max divisor cannot overflow it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt[ch]   <= '0;
        div_q[ch] <= '0;
        phase[ch] <= 1'b0;
      end else if (div_q[ch] < DIV_W'(2)) begin
        cnt[ch]   <= '0;
        phase[ch] <= 1'b0;
        div_q[ch] <= div_in[ch];
      end else if (cnt[ch] >= div_q[ch] - DIV_W'(1)) begin
        cnt[ch]   <= '0;
        phase[ch] <= ~phase[ch];
        div_q[ch] <= div_in[ch];
      end else begin
        cnt[ch]   <= cnt[ch] + DIV_W'(1);
      end
    end

    always_comb begin
      sample_next[ch] = 16'd0;
      if (!bus.mute && vol_q != 3'd0 && div_q[ch] >= DIV_W'(2)) begin
        sample_next[ch] = phase[ch] ? amp : amp_neg;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        audio_q[ch] <= 16'd0;
      end else begin
        audio_q[ch] <= sample_next[ch];
      end
    end
  end

  assign bus.vol     = vol_q;
  assign bus.audio_l = audio_q[0];
  assign bus.audio_r = audio_q[1];

endmodule

// File: tb/tb_tone_gen.sv
// Scoreboard bench for tone_gen: a cycle-indexed tone model predicts {vol, audio_l, audio_r}
// after every clock edge, and a monitor compares the DUT outputs against the queued predictions.
module tb_tone_gen;

  localparam int DIV_W = 10;
  localparam int DMAX  = (1 << DIV_W) - 1;

  logic clk;
  logic rst_n;

  tone_gen_if #(.DIV_W(DIV_W)) tif ();

  tone_gen #(.DIV_W(DIV_W), .AMP_SHIFT(12), .VOL_INIT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tif.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [34:0] exp_q[$];

  task automatic check(input string name, input logic [34:0] got, input logic [34:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // reference model: half-periods tracked as absolute cycle numbers of the next toggle
  int      m_lat    [2] = '{0, 0};
  int      m_ph     [2] = '{0, 0};
  longint  m_toggle [2] = '{0, 0};
  int      m_vol        = 3;
  bit      m_up_p       = 0;
  bit      m_dn_p       = 0;
  longint  m_cyc        = 0;

  function automatic logic [15:0] level(input int vol, input int ph);
    int a;
    a = vol * 4096;
    if (ph != 0) return 16'(a);
    return 16'((65536 - a) % 65536);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_lat    = '{0, 0};
        m_ph     = '{0, 0};
        m_toggle = '{0, 0};
        m_vol    = 3;
        m_up_p   = 0;
        m_dn_p   = 0;
        exp_q.delete();
      end else begin
        logic [15:0] a [2];
        int din [2];
        bit ue, de;
        m_cyc++;
        din[0] = int'(tif.div_l);
        din[1] = int'(tif.div_r);
        for (int c = 0; c < 2; c++) begin
          if (tif.mute || m_vol == 0 || m_lat[c] < 2) a[c] = 16'd0;
          else a[c] = level(m_vol, m_ph[c]);
        end
        ue = tif.vol_up && !m_up_p;
        de = tif.vol_dn && !m_dn_p;
        m_up_p = tif.vol_up;
        m_dn_p = tif.vol_dn;
        if (ue && !de) m_vol = (m_vol == 7) ? 7 : m_vol + 1;
        if (de && !ue) m_vol = (m_vol == 0) ? 0 : m_vol - 1;
        for (int c = 0; c < 2; c++) begin
          if (m_lat[c] < 2) begin
            m_lat[c] = din[c];
            m_ph[c]  = 0;
            m_toggle[c] = m_cyc + m_lat[c];
          end else if (m_cyc == m_toggle[c]) begin
            m_ph[c]  = 1 - m_ph[c];
            m_lat[c] = din[c];
            m_toggle[c] = m_cyc + m_lat[c];
          end
        end
        exp_q.push_back({3'(m_vol), a[0], a[1]});
      end
    end
  end

  // monitor: outputs are valid every cycle, checked 1 ns after each edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (exp_q.size() == 0) check("sample_underflow", 35'd1, 35'd0);
        else check("sample", {tif.vol, tif.audio_l, tif.audio_r}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic set_div(input int l, input int r);
    @(negedge clk);
    tif.div_l = DIV_W'(l);
    tif.div_r = DIV_W'(r);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  int vol_tab [5] = '{4, 5, 6, 7, 7};

  initial begin
    rst_n      = 1'b0;
    tif.div_l  = '0;
    tif.div_r  = '0;
    tif.vol_up = 1'b0;
    tif.vol_dn = 1'b0;
    tif.mute   = 1'b0;
    run(3);
    check("reset_vol", {32'd0, tif.vol}, 35'd3);
    check("reset_audio", {3'd0, tif.audio_l, tif.audio_r}, 35'd0);
    rst_n = 1'b1;

    // basic tone D=4, right silent; then retune mid-half-period
    set_div(4, 0);
    run(41);
    set_div(2, 0);
    run(20);

    // volume up five times
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) tif.vol_up = 1'b1;
      @(negedge clk) tif.vol_up = 1'b0;
      check("vol_up_step", {32'd0, tif.vol}, 35'(vol_tab[i]));
      run(2);
    end
    @(negedge clk) tif.vol_dn = 1'b1;
    run(100);
    check("vol_dn_hold", {32'd0, tif.vol}, 35'd6);
    tif.vol_dn = 1'b0;
    run(2);

    // simultaneous edges
    @(negedge clk) begin tif.vol_up = 1'b1; tif.vol_dn = 1'b1; end
    run(2);
    check("vol_both", {32'd0, tif.vol}, 35'd6);
    tif.vol_up = 1'b0;
    tif.vol_dn = 1'b0;

    // mute over a few half-periods
    @(negedge clk) tif.mute = 1'b1;
    run(7);
    tif.mute = 1'b0;
    run(10);

    // left D=3 with right at 1, then right at 5
    set_div(3, 1);
    run(30);
    set_div(3, 5);
    run(40);

    // largest divisor, then back to a short one
    set_div(DMAX, 5);
    run(2 * DMAX + 20);
    set_div(6, 2);
    run(30);

    // randomized stretch
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) tif.div_l = DIV_W'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) tif.div_r = DIV_W'($urandom_range(0, 9));
      tif.vol_up = 1'($urandom_range(0, 1));
      tif.vol_dn = 1'($urandom_range(0, 1));
      tif.mute   = ($urandom_range(0, 7) == 0);
      run($urandom_range(0, 4));
    end

    // asynchronous reset mid-tone, between edges
    set_div(4, 3);
    tif.mute   = 1'b0;
    tif.vol_up = 1'b0;
    tif.vol_dn = 1'b0;
    run(4);
    @(negedge clk) tif.vol_up = 1'b1;
    run(12);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_vol", {32'd0, tif.vol}, 35'd3);
    check("async_rst_l", {19'd0, tif.audio_l}, 35'd0);
    check("async_rst_r", {19'd0, tif.audio_r}, 35'd0);
    tif.vol_up = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(40);

    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      tif.div_l  = DIV_W'($urandom_range(0, 7));
      tif.div_r  = DIV_W'($urandom_range(0, 7));
      tif.vol_up = 1'($urandom_range(0, 1));
      tif.vol_dn = 1'($urandom_range(0, 1));
      tif.mute   = ($urandom_range(0, 5) == 0);
      run($urandom_range(0, 6));
    end
    run(3);
    check("queue_drained", 35'(exp_q.size()), 35'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tone_gen.md
# tone_gen

Stereo square-wave tone generator feeding the I2S speaker serializer. Takes a half-period divisor per channel and a user volume control, and produces registered 16-bit two's-complement samples `audio_l` / `audio_r` that the serializer shifts out continuously. Volume is held in a saturating 3-bit register driven by edge-detected up/down buttons. Divisor changes take effect only at a half-period boundary, so retuning never produces a runt pulse.

## Interface
- `DIV_W`, 22: width of the half-period divisor; max half-period is 2^DIV_W−1 clk cycles.
- `AMP_SHIFT`, 12: amplitude = `vol << AMP_SHIFT`.
- `VOL_INIT`, 3: volume after reset, range 0..7.
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `div_l`  in  DIV_W  left half-period in clk cycles; values 0 and 1 mean silence.
- `div_r`  in  DIV_W  right half-period; same encoding as `div_l`.
- `vol_up`  in  1  debounced level; each rising edge increments volume.
- `vol_dn`  in  1  debounced level; each rising edge decrements volume.
- `mute`  in  1  level; forces both outputs to 0 while high.
- `vol`  out  3  current volume, registered.
- `audio_l`  out  16  left sample, two's complement, registered.
- `audio_r`  out  16  right sample, two's complement, registered.

## Operation
- Each channel is independent and identical. Per channel it holds `cnt` (DIV_W), `div_q` (latched divisor) and `phase` (1 bit).
- Active when `div_q >= 2`:
  - If `cnt >= div_q−1`: `cnt` ← 0, `phase` toggles, `div_q` ← current `div_*` input.
  - Otherwise: `cnt` increments.
  - The `>=` compare makes a latched divisor that is smaller than the running count wrap on the next cycle, with no long runaway.
- Silent when `div_q < 2`:
  - `cnt` ← 0, `phase` ← 0, and `div_q` ← the `div_*` input every cycle.
  - A new valid divisor therefore starts counting on the cycle after it is latched.
- Sample value:
  - `amp = {vol, AMP_SHIFT zeros}` zero-extended to 16 bits (vol 7 → 0x7000).
  - Output is `+amp` when `phase` = 1 and `−amp` (two's complement) when `phase` = 0.
  - Output is 0 when `mute` = 1, `vol` = 0, or the channel is silent.
- Volume:
  - Rising edges are detected against a registered copy of each button input.
  - Up edge alone: `vol` ← min(vol+1, 7). Down edge alone: `vol` ← max(vol−1, 0).
  - Both edges in the same cycle: no change.
  - Holding a button high gives exactly one step.
- Outputs are registered and change only on `clk` edges. The serializer samples them asynchronously to its frame, and mid-frame changes are acceptable.

## Timing
- Reset values:
  - `cnt` = 0, `phase` = 0, `div_q` = 0.
  - `vol` = VOL_INIT, button history = 0.
  - `audio_l` = `audio_r` = 0.
- Reset deassertion mid-tone restarts from silence. The divisor is re-latched on the first clock after reset.
- Output period for a latched divisor D ≥ 2 is 2·D clk cycles at a 50 % duty cycle. `audio_*` reflects `phase` with 1 cycle of latency.
- Divisor change: the old D completes the current half-period, and the new D governs the very next half-period.
- Volume/mute latency:
  - A button edge at cycle n updates `vol` at n+1 and `audio_*` at n+2.
  - `mute` registered at n affects `audio_*` at n+1.
- Boundary conditions:
  - Wrap at D = 2^DIV_W−1 must not overflow `cnt`.
  - The `vol` update computation has no overflow at 7 or underflow at 0.

## Test plan
- Reset, then `div_l`=4, `vol` at init 3 → `audio_l` alternates 0x3000 / 0xD000, with 4 cycles at each level, period 8; `audio_r` stays 0 with `div_r`=0.
- While running at D=4, change `div_l` to 2 mid-half-period → the current half-period completes at length 4, then half-periods become 2 cycles.
- Pulse `vol_up` five times from 3 → `vol` reads 4,5,6,7,7 and high level becomes 0x7000. Then hold `vol_dn` high for 100 cycles → `vol` = 6 exactly once.
- Assert `vol_up` and `vol_dn` rising in the same cycle → `vol` unchanged. Assert `mute` → both outputs 0 within 1 cycle, tone phase continues, and the output resumes at the correct sign on release.
- Set `div_r` = 1 while the left channel runs at D=3 → `audio_r` = 0, left period = 6. Then set `div_r` = 5 → the right channel starts at −amp and toggles every 5 cycles.
- Assert `rst_n` low mid-tone, asynchronously between edges → all outputs 0 and `vol` = 3 immediately, without waiting for a clock edge.
